// File: rtl/cpu_run_controller.sv
// Run sequencer for the pipelined BPF CPU: arbitrates instruction memory between the
// program loader and packet execution, and delivers each packet's verdict downstream.
module cpu_run_controller #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_ready,
    output logic             pkt_release,
    input  logic             prog_wr_req,
    output logic             prog_wr_gnt,
    output logic             cpu_halt,
    output logic             PC_rst,
    input  logic             cpu_ret,
    input  logic [31:0]      cpu_ret_val,
    output logic             verdict_valid,
    input  logic             verdict_ready,
    output logic             verdict_accept,
    output logic [31:0]      verdict_len,
    output logic             verdict_timeout,
    output logic [CNT_W-1:0] cycles_used
);

    typedef enum logic [2:0] {StIdle, StStart, StRun, StDone, StLoad} state_e;

    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TimeoutCnt  = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_q, accept_d;
    logic [31:0]        len_q, len_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            accept_q  <= 1'b0;
            len_q     <= '0;
            timeout_q <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            accept_q  <= accept_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
            cycles_q  <= cycles_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_d  = accept_q;
        len_d     = len_q;
        timeout_d = timeout_q;
        cycles_d  = cycles_q;
        unique case (state_q)
            StIdle: begin
                // Loader wins ties so a program update is never starved by traffic.
                if (prog_wr_req) begin
                    state_d = StLoad;
                end else if (pkt_ready) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cpu_ret) begin
                    accept_d  = (cpu_ret_val != 32'd0);
                    len_d     = cpu_ret_val;
                    timeout_d = 1'b0;
                    cycles_d  = cnt_q + CNT_W'(1);
                    state_d   = StDone;
                end else if (cnt_q == TimeoutLast) begin
                    accept_d  = 1'b0;
                    len_d     = '0;
                    timeout_d = 1'b1;
                    cycles_d  = TimeoutCnt;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (verdict_ready) begin
                    state_d = StIdle;
                end
            end
            StLoad: begin
                if (!prog_wr_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cpu_halt        = (state_q != StRun);
    assign PC_rst          = (state_q == StStart);
    assign verdict_valid   = (state_q == StDone);
    assign pkt_release     = (state_q == StDone) && verdict_ready;
    assign prog_wr_gnt     = (state_q == StLoad) && prog_wr_req;
    assign verdict_accept  = accept_q;
    assign verdict_len     = len_q;
    assign verdict_timeout = timeout_q;
    assign cycles_used     = cycles_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with TIMEOUT=8: vector table plus corner-case sequences.
module tb_cpu_run_controller;

    localparam int unsigned Tmo  = 8;
    localparam int unsigned CntW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            pkt_ready;
    logic            pkt_release;
    logic            prog_wr_req;
    logic            prog_wr_gnt;
    logic            cpu_halt;
    logic            PC_rst;
    logic            cpu_ret;
    logic [31:0]     cpu_ret_val;
    logic            verdict_valid;
    logic            verdict_ready;
    logic            verdict_accept;
    logic [31:0]     verdict_len;
    logic            verdict_timeout;
    logic [CntW-1:0] cycles_used;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_run_controller #(
        .TIMEOUT (Tmo),
        .CNT_W   (CntW)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .pkt_ready       (pkt_ready),
        .pkt_release     (pkt_release),
        .prog_wr_req     (prog_wr_req),
        .prog_wr_gnt     (prog_wr_gnt),
        .cpu_halt        (cpu_halt),
        .PC_rst          (PC_rst),
        .cpu_ret         (cpu_ret),
        .cpu_ret_val     (cpu_ret_val),
        .verdict_valid   (verdict_valid),
        .verdict_ready   (verdict_ready),
        .verdict_accept  (verdict_accept),
        .verdict_len     (verdict_len),
        .verdict_timeout (verdict_timeout),
        .cycles_used     (cycles_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pkt;
        logic        req;
        logic        ret;
        logic [31:0] val;
        logic        rdy;
        logic        halt;
        logic        pcr;
        logic        gnt;
        logic        rel;
        logic        vld;
        logic        chkf;
        logic        acc;
        logic [31:0] len;
        logic        tmo;
        logic [15:0] cyc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pkt, input logic req, input logic ret,
                         input logic [31:0] val, input logic rdy);
        pkt_ready     = pkt;
        prog_wr_req   = req;
        cpu_ret       = ret;
        cpu_ret_val   = val;
        verdict_ready = rdy;
        #1;
    endtask

    task automatic chk_verdict(input string tag, input logic acc, input logic [31:0] len,
                               input logic tmo, input logic [15:0] cyc);
        chk({tag, ".valid"},   {31'd0, verdict_valid},   32'd1);
        chk({tag, ".accept"},  {31'd0, verdict_accept},  {31'd0, acc});
        chk({tag, ".len"},     verdict_len,              len);
        chk({tag, ".timeout"}, {31'd0, verdict_timeout}, {31'd0, tmo});
        chk({tag, ".cycles"},  {16'd0, cycles_used},     {16'd0, cyc});
    endtask

    // From IDLE: one cycle of pkt_ready, check START, leave the DUT in its first RUN cycle.
    task automatic start_packet(input string tag);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk({tag, ".pc_rst"}, {31'd0, PC_rst},   32'd1);
        chk({tag, ".start_halt"}, {31'd0, cpu_halt}, 32'd1);
        tick();
    endtask

    initial begin
        int   runs;
        int   rels;
        logic ok;

        //        pkt req ret val    rdy halt pcr gnt rel vld chkf acc len    tmo cyc
        vecs[0]  = '{0, 0, 0, 32'h0,  0,  1,   0,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[1]  = '{1, 0, 0, 32'h0,  0,  1,   0,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[2]  = '{0, 0, 0, 32'h0,  0,  1,   1,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[3]  = '{0, 0, 0, 32'h0,  0,  0,   0,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[4]  = '{0, 0, 0, 32'h0,  0,  0,   0,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[5]  = '{0, 0, 1, 32'h40, 0,  0,   0,  0,  0,  0,  1,   0,  32'h0,  0,  16'd0};
        vecs[6]  = '{0, 0, 0, 32'h0,  1,  1,   0,  0,  1,  1,  1,   1,  32'h40, 0,  16'd3};
        vecs[7]  = '{1, 1, 0, 32'h0,  0,  1,   0,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[8]  = '{1, 1, 0, 32'h0,  0,  1,   0,  1,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[9]  = '{1, 0, 0, 32'h0,  0,  1,   0,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[10] = '{1, 0, 0, 32'h0,  0,  1,   0,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[11] = '{0, 0, 0, 32'h0,  0,  1,   1,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[12] = '{0, 0, 1, 32'h0,  0,  0,   0,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};
        vecs[13] = '{0, 0, 0, 32'h0,  0,  1,   0,  0,  0,  1,  1,   0,  32'h0,  0,  16'd1};
        vecs[14] = '{0, 0, 0, 32'h0,  1,  1,   0,  0,  1,  1,  1,   0,  32'h0,  0,  16'd1};
        vecs[15] = '{0, 0, 0, 32'h0,  0,  1,   0,  0,  0,  0,  0,   0,  32'h0,  0,  16'd0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].pkt, vecs[i].req, vecs[i].ret, vecs[i].val, vecs[i].rdy);
            chk($sformatf("v%0d.halt", i), {31'd0, cpu_halt},      {31'd0, vecs[i].halt});
            chk($sformatf("v%0d.pcrst", i), {31'd0, PC_rst},       {31'd0, vecs[i].pcr});
            chk($sformatf("v%0d.gnt", i), {31'd0, prog_wr_gnt},    {31'd0, vecs[i].gnt});
            chk($sformatf("v%0d.rel", i), {31'd0, pkt_release},    {31'd0, vecs[i].rel});
            chk($sformatf("v%0d.valid", i), {31'd0, verdict_valid}, {31'd0, vecs[i].vld});
            if (vecs[i].chkf) begin
                chk($sformatf("v%0d.accept", i), {31'd0, verdict_accept}, {31'd0, vecs[i].acc});
                chk($sformatf("v%0d.len", i), verdict_len, vecs[i].len);
                chk($sformatf("v%0d.tmo", i), {31'd0, verdict_timeout}, {31'd0, vecs[i].tmo});
                chk($sformatf("v%0d.cyc", i), {16'd0, cycles_used}, {16'd0, vecs[i].cyc});
            end
            tick();
        end

        // Runaway program: exactly TIMEOUT RUN cycles, then a forced reject.
        start_packet("tmo");
        runs = 0;
        while (!cpu_halt && runs < 50) begin
            runs++;
            tick();
        end
        chk("tmo.run_cycles", runs, Tmo);
        chk_verdict("tmo", 1'b0, 32'd0, 1'b1, 16'(Tmo));
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("tmo.release", {31'd0, pkt_release}, 32'd1);
        tick();

        // RET on the last allowed cycle beats the timeout.
        start_packet("edge");
        for (int i = 0; i < Tmo - 1; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 32'h123, 1'b0);
        chk("edge.run", {31'd0, cpu_halt}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk_verdict("edge", 1'b1, 32'h123, 1'b0, 16'(Tmo));
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick();

        // Backpressure: fields stay put, late RET pulses ignored, single release.
        start_packet("bp");
        drive(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
        tick();
        ok   = 1'b1;
        rels = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, (i % 3) == 1, 32'h0, 1'b0);
            if (!verdict_valid || !verdict_accept || verdict_len != 32'h55 ||
                verdict_timeout || cycles_used != 16'd1) begin
                ok = 1'b0;
            end
            if (pkt_release) rels++;
            tick();
        end
        chk("bp.stable", {31'd0, ok}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk_verdict("bp.hs", 1'b1, 32'h55, 1'b0, 16'd1);
        if (pkt_release) rels++;
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        if (pkt_release) rels++;
        chk("bp.idle_valid", {31'd0, verdict_valid}, 32'd0);
        chk("bp.releases", rels, 1);
        tick();

        // Loader request mid-RUN waits for the handshake, then LOAD two cycles later.
        start_packet("mid");
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mid.run_gnt", {31'd0, prog_wr_gnt}, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h9, 1'b0);
        chk("mid.still_run", {31'd0, cpu_halt}, 32'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mid.done_gnt", {31'd0, prog_wr_gnt}, 32'd0);
        chk("mid.done_valid", {31'd0, verdict_valid}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("mid.hs_gnt", {31'd0, prog_wr_gnt}, 32'd0);
        chk("mid.hs_rel", {31'd0, pkt_release}, 32'd1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("mid.idle_gnt", {31'd0, prog_wr_gnt}, 32'd0);
        tick();
        chk("mid.load_gnt", {31'd0, prog_wr_gnt}, 32'd1);
        chk("mid.load_halt", {31'd0, cpu_halt}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("mid.drop_gnt", {31'd0, prog_wr_gnt}, 32'd0);
        tick();

        // Synchronous reset after 5 RUN cycles with pkt_ready held high.
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("rst.pre_run", {31'd0, cpu_halt}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst.pre_rel", {31'd0, pkt_release}, 32'd0);
        tick();
        chk("rst.halt", {31'd0, cpu_halt}, 32'd1);
        chk("rst.valid", {31'd0, verdict_valid}, 32'd0);
        chk("rst.rel", {31'd0, pkt_release}, 32'd0);
        chk("rst.pcrst", {31'd0, PC_rst}, 32'd0);
        chk("rst.cycles", {16'd0, cycles_used}, 32'd0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("rst.idle_stays", {31'd0, PC_rst}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
